// File: rtl/audioport_pkg.sv
// audioport_pkg: constants, FSM state type and the scale/clamp helper shared by
// level_scaler and serial_multiplier.
//   AUDIO_W / GAIN_W / PROD_W : sample, gain and product widths
//   LEVEL_UNITY               : gain of 1.0 in unsigned Q1.15
//   LEVEL_FRAC_BITS           : number of fractional gain bits
//   SCALER_LATENCY            : cycles from accepted tick to valid_out
//   CFG_MONO                  : bit of the config word that selects mono mix
package audioport_pkg;

  localparam int AUDIO_W         = 24;
  localparam int GAIN_W          = 16;
  localparam int PROD_W          = 40;
  localparam int LEVEL_FRAC_BITS = 15;
  localparam int SCALER_LATENCY  = 18;
  localparam int CFG_MONO        = 1;

  localparam logic [GAIN_W-1:0]  LEVEL_UNITY = 16'h8000;
  localparam logic [AUDIO_W-1:0] SAMPLE_MAX  = 24'h7FFFFF;
  localparam logic [AUDIO_W-1:0] SAMPLE_MIN  = 24'h800000;

  localparam logic signed [PROD_W-1:0] SAMPLE_MAX_EXT = 40'sd8388607;
  localparam logic signed [PROD_W-1:0] SAMPLE_MIN_EXT = -40'sd8388608;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } scaler_state_e;

  typedef struct packed {
    logic [AUDIO_W-1:0] sample;
    logic               clipped;
  } scaled_t;

  // Drop the Q1.15 fraction (arithmetic shift, i.e. floor) and clamp to the
  // signed 24-bit range, reporting whether clamping happened.
  function automatic scaled_t scale_clamp(input logic signed [PROD_W-1:0] product);
    logic signed [PROD_W-1:0] shifted;
    scaled_t r;
    shifted   = product >>> LEVEL_FRAC_BITS;
    r.sample  = shifted[AUDIO_W-1:0];
    r.clipped = 1'b0;
    if (shifted > SAMPLE_MAX_EXT) begin
      r.sample  = SAMPLE_MAX;
      r.clipped = 1'b1;
    end else if (shifted < SAMPLE_MIN_EXT) begin
      r.sample  = SAMPLE_MIN;
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_multiplier.sv
// serial_multiplier: 24-bit signed x 16-bit unsigned shift-add multiplier,
// one gain bit (LSB first) per cycle, 16 cycles per product.
//   clk, rst_n   : clock, synchronous active-low reset
//   start_in     : load operands and begin (ignored while abort_in=1)
//   abort_in     : drop any computation in progress
//   sample_in    : signed multiplicand
//   gain_in      : unsigned multiplier
//   product_out  : signed 40-bit product, valid when done_out=1
//   done_out     : one-cycle pulse, first cycle the finished product is visible
module serial_multiplier
  import audioport_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_in,
  input  logic                     abort_in,
  input  logic [AUDIO_W-1:0]       sample_in,
  input  logic [GAIN_W-1:0]        gain_in,
  output logic signed [PROD_W-1:0] product_out,
  output logic                     done_out
);

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (abort_in) begin
      run_d = 1'b0;
    end else if (start_in) begin
      mcand_d = {{(PROD_W-AUDIO_W){sample_in[AUDIO_W-1]}}, sample_in};
      gain_d  = gain_in;
      acc_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      // Gain is unsigned, so every set bit simply adds the shifted sample.
      if (gain_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      gain_d  = gain_q >> 1;
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      gain_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign product_out = acc_q;
  assign done_out    = done_q;

endmodule

// File: rtl/level_scaler.sv
// level_scaler: per-channel Q1.15 gain with optional mono mix and saturation.
//   clk, rst_n              : clock, synchronous active-low reset
//   tick_in, audio0/1_in    : sample strobe and signed 24-bit L/R samples
//   play_in, clr_in         : play state, clear pulse
//   cfg_in, cfg_reg_in      : config load pulse / word (mono bit)
//   level_in, level_reg_in  : gain load pulse / word ([15:0] L, [31:16] R)
//   audio0/1_out            : scaled samples, held until next result/clr/stop
//   valid_out, sat_out      : result strobe, clip flag (pulses with valid_out)
//   busy_out, tick_lost_out : computing, dropped-tick pulse
module level_scaler
  import audioport_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_in,
  input  logic [AUDIO_W-1:0] audio0_in,
  input  logic [AUDIO_W-1:0] audio1_in,
  input  logic               play_in,
  input  logic               clr_in,
  input  logic               cfg_in,
  input  logic [31:0]        cfg_reg_in,
  input  logic               level_in,
  input  logic [31:0]        level_reg_in,
  output logic [AUDIO_W-1:0] audio0_out,
  output logic [AUDIO_W-1:0] audio1_out,
  output logic               valid_out,
  output logic               busy_out,
  output logic               sat_out,
  output logic               tick_lost_out
);

  scaler_state_e      state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [GAIN_W-1:0]  gain_l_q, gain_l_d, gain_r_q, gain_r_d;
  logic               mono_q, mono_d;
  logic [AUDIO_W-1:0] audio0_q, audio0_d, audio1_q, audio1_d;
  logic               valid_q, valid_d, sat_q, sat_d, lost_q, lost_d;

  logic               accept, abort;
  logic [AUDIO_W:0]   mix_sum;
  logic [AUDIO_W-1:0] op0, op1;
  logic [GAIN_W-1:0]  gain1_sel;
  logic signed [PROD_W-1:0] prod0, prod1;
  logic               done0, done1;
  scaled_t            res0, res1;
  logic               unused_bits;

  assign unused_bits = ^{cfg_reg_in, mix_sum[0]};

  // Stop (play low) and clear both cancel work and blank the outputs.
  assign abort  = clr_in || !play_in;
  assign accept = (state_q == ST_IDLE) && tick_in && play_in && !clr_in;

  // 25-bit sum then >>>1 always fits back in 24 bits.
  assign mix_sum   = {audio0_in[AUDIO_W-1], audio0_in} + {audio1_in[AUDIO_W-1], audio1_in};
  assign op0       = mono_q ? mix_sum[AUDIO_W:1] : audio0_in;
  assign op1       = mono_q ? mix_sum[AUDIO_W:1] : audio1_in;
  assign gain1_sel = mono_q ? gain_l_q : gain_r_q;

  serial_multiplier u_mul0 (
    .clk(clk), .rst_n(rst_n), .start_in(accept), .abort_in(abort),
    .sample_in(op0), .gain_in(gain_l_q), .product_out(prod0), .done_out(done0)
  );

  serial_multiplier u_mul1 (
    .clk(clk), .rst_n(rst_n), .start_in(accept), .abort_in(abort),
    .sample_in(op1), .gain_in(gain1_sel), .product_out(prod1), .done_out(done1)
  );

  assign res0 = scale_clamp(prod0);
  assign res1 = scale_clamp(prod1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    audio0_d = audio0_q;
    audio1_d = audio1_q;
    valid_d  = 1'b0;
    sat_d    = 1'b0;
    lost_d   = tick_in && play_in && !clr_in && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MUL;
          cnt_d   = '0;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_SAT;
        end
      end
      ST_SAT: begin
        state_d = ST_OUT;
        if (done0 && done1) begin
          audio0_d = res0.sample;
          audio1_d = res1.sample;
          valid_d  = 1'b1;
          sat_d    = res0.clipped || res1.clipped;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      audio0_d = '0;
      audio1_d = '0;
      valid_d  = 1'b0;
      sat_d    = 1'b0;
    end

    // Gains used by a tick are the ones registered before it, since the
    // multipliers latch gain_*_q rather than level_reg_in.
    gain_l_d = gain_l_q;
    gain_r_d = gain_r_q;
    mono_d   = mono_q;
    if (clr_in) begin
      gain_l_d = LEVEL_UNITY;
      gain_r_d = LEVEL_UNITY;
      mono_d   = 1'b0;
    end else begin
      if (level_in) begin
        gain_l_d = level_reg_in[15:0];
        gain_r_d = level_reg_in[31:16];
      end
      if (cfg_in) begin
        mono_d = cfg_reg_in[CFG_MONO];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gain_l_q <= LEVEL_UNITY;
      gain_r_q <= LEVEL_UNITY;
      mono_q   <= 1'b0;
      audio0_q <= '0;
      audio1_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gain_l_q <= gain_l_d;
      gain_r_q <= gain_r_d;
      mono_q   <= mono_d;
      audio0_q <= audio0_d;
      audio1_q <= audio1_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      lost_q   <= lost_d;
    end
  end

  assign audio0_out    = audio0_q;
  assign audio1_out    = audio1_q;
  assign valid_out     = valid_q;
  assign sat_out       = sat_q;
  assign tick_lost_out = lost_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_level_scaler.sv
// tb_level_scaler: directed stimulus with a scoreboard queue of expected
// results; a monitor pops and compares on every valid_out.
module tb_level_scaler;
  import audioport_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, tick_in, play_in, clr_in, cfg_in, level_in;
  logic [23:0] audio0_in, audio1_in;
  logic [31:0] cfg_reg_in, level_reg_in;
  logic [23:0] audio0_out, audio1_out;
  logic        valid_out, busy_out, sat_out, tick_lost_out;

  level_scaler dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
    .audio0_in(audio0_in), .audio1_in(audio1_in),
    .play_in(play_in), .clr_in(clr_in),
    .cfg_in(cfg_in), .cfg_reg_in(cfg_reg_in),
    .level_in(level_in), .level_reg_in(level_reg_in),
    .audio0_out(audio0_out), .audio1_out(audio1_out),
    .valid_out(valid_out), .busy_out(busy_out),
    .sat_out(sat_out), .tick_lost_out(tick_lost_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] a0;
    logic [23:0] a1;
    logic        sat;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got a0=%h a1=%h with no pending tick (cycle %0d)",
                 audio0_out, audio1_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn cycle=%0d a0=%h a1=%h sat=%b (expected %h %h %b at cycle %0d)",
                 cyc, audio0_out, audio1_out, sat_out, e.a0, e.a1, e.sat, e.due);
        chk("audio0", {8'h0, audio0_out}, {8'h0, e.a0});
        chk("audio1", {8'h0, audio1_out}, {8'h0, e.a1});
        chk("sat", {31'h0, sat_out}, {31'h0, e.sat});
        chk("latency", 32'(cyc), 32'(e.due));
        chk("busy_in_out", {31'h0, busy_out}, 32'h1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_level(input logic [15:0] l, input logic [15:0] r);
    level_reg_in = {r, l};
    level_in = 1'b1;
    step(1);
    level_in = 1'b0;
  endtask

  task automatic set_mono(input logic m);
    cfg_reg_in = '0;
    cfg_reg_in[CFG_MONO] = m;
    cfg_in = 1'b1;
    step(1);
    cfg_in = 1'b0;
  endtask

  task automatic send_tick(input logic [23:0] a0, input logic [23:0] a1,
                           input logic [23:0] e0, input logic [23:0] e1,
                           input logic es, input bit push);
    exp_t e;
    audio0_in = a0;
    audio1_in = a1;
    tick_in   = 1'b1;
    if (push) begin
      e.a0 = e0; e.a1 = e1; e.sat = es; e.due = cyc + SCALER_LATENCY;
      sb.push_back(e);
    end
    step(1);
    tick_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; play_in = 1'b0; clr_in = 1'b0;
    cfg_in = 1'b0; level_in = 1'b0; cfg_reg_in = '0; level_reg_in = '0;
    audio0_in = '0; audio1_in = '0;
    step(3);
    @(negedge clk);
    chk("rst_audio0", {8'h0, audio0_out}, 32'h0);
    chk("rst_audio1", {8'h0, audio1_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_busy", {31'h0, busy_out}, 32'h0);
    chk("rst_sat", {31'h0, sat_out}, 32'h0);
    chk("rst_lost", {31'h0, tick_lost_out}, 32'h0);
    step(1);
    rst_n = 1'b1;
    play_in = 1'b1;
    step(2);

    // Unity gain passes samples through unchanged.
    send_tick(24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 1'b0, 1'b1);
    chk("busy_after_tick", {31'h0, busy_out}, 32'h1);
    step(20);

    // Half gain on the right: most negative sample halves exactly.
    set_level(16'h8000, 16'h4000);
    send_tick(24'h000010, 24'h800000, 24'h000010, 24'hC00000, 1'b0, 1'b1);
    step(20);

    // Near-double gain on the left clips both ways; -1 * 0.5 floors to -1.
    set_level(16'hFFFF, 16'h4000);
    send_tick(24'h700000, 24'h000000, 24'h7FFFFF, 24'h000000, 1'b1, 1'b1);
    step(20);
    send_tick(24'h900000, 24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b1, 1'b1);
    step(20);

    // Mono mix at unity; a gain load in the tick cycle applies to the next tick.
    set_level(16'h8000, 16'h8000);
    set_mono(1'b1);
    level_reg_in = {16'h4000, 16'h4000};
    level_in = 1'b1;
    send_tick(24'h000100, 24'h000300, 24'h000200, 24'h000200, 1'b0, 1'b1);
    level_in = 1'b0;
    step(20);
    send_tick(24'h000100, 24'h000300, 24'h000100, 24'h000100, 1'b0, 1'b1);
    step(20);
    set_mono(1'b0);
    set_level(16'h8000, 16'h8000);

    // Tick 5 cycles into a computation is dropped and flagged.
    send_tick(24'h000123, 24'h000456, 24'h000123, 24'h000456, 1'b0, 1'b1);
    step(4);
    send_tick(24'h7FFFFF, 24'h7FFFFF, 24'h0, 24'h0, 1'b0, 1'b0);
    chk("tick_lost_pulse", {31'h0, tick_lost_out}, 32'h1);
    step(1);
    chk("tick_lost_one_cycle", {31'h0, tick_lost_out}, 32'h0);
    step(20);

    // Clear together with a tick while busy: clear wins, nothing lost.
    send_tick(24'h000555, 24'h000666, 24'h0, 24'h0, 1'b0, 1'b0);
    step(2);
    tick_in = 1'b1;
    clr_in  = 1'b1;
    step(1);
    tick_in = 1'b0;
    clr_in  = 1'b0;
    chk("clr_tick_lost", {31'h0, tick_lost_out}, 32'h0);
    chk("clr_tick_busy", {31'h0, busy_out}, 32'h0);
    chk("clr_tick_audio0", {8'h0, audio0_out}, 32'h0);
    step(25);

    // Abort at MUL cycle 7 via clear, stop, and reset.
    for (int v = 0; v < 3; v++) begin
      send_tick(24'h111111, 24'h222222, 24'h111111, 24'h222222, 1'b0, 1'b1);
      step(20);
      send_tick(24'h333333, 24'h444444, 24'h0, 24'h0, 1'b0, 1'b0);
      step(6);
      if (v == 0) clr_in = 1'b1;
      else if (v == 1) play_in = 1'b0;
      else rst_n = 1'b0;
      step(1);
      clr_in = 1'b0;
      play_in = 1'b1;
      rst_n = 1'b1;
      chk($sformatf("abort%0d_busy", v), {31'h0, busy_out}, 32'h0);
      chk($sformatf("abort%0d_audio0", v), {8'h0, audio0_out}, 32'h0);
      chk($sformatf("abort%0d_audio1", v), {8'h0, audio1_out}, 32'h0);
      chk($sformatf("abort%0d_valid", v), {31'h0, valid_out}, 32'h0);
      step(25);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
